// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: iterative divider, store strobes, alignment check.
// Optional divider built only when EX_DIV_EN is defined.
module ex_stage_mc #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid_i,
    input  logic                mem_allowin_i,
    input  logic                ex_flush_i,
    output logic                ex_allowin_o,
    output logic                ex_to_mem_valid_o,
    input  logic                div_en_i,
    input  logic                div_signed_i,
    input  logic                div_rem_i,
    input  logic [DATA_W-1:0]   oper1_i,
    input  logic [DATA_W-1:0]   oper2_i,
    input  logic [DATA_W-1:0]   alu_rl_i,
    input  logic                regs_we_i,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [1:0]          mem_size_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   result_o,
    output logic                regs_we_o,
    output logic [DATA_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_ale_o
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    logic              w_ready_go;
    logic [DATA_W-1:0] w_div_res;

`ifdef EX_DIV_EN
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_result;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic              r_sel_rem;

    logic              w_issue;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nx;
    logic [DATA_W-1:0] w_quo_nx;
    logic [DATA_W-1:0] w_q_fin;
    logic [DATA_W-1:0] w_r_fin;

    assign w_issue = (r_state == S_IDLE) & ex_valid_i & div_en_i & !ex_flush_i;
    assign w_a_neg = div_signed_i & oper1_i[DATA_W-1];
    assign w_b_neg = div_signed_i & oper2_i[DATA_W-1];
    assign w_abs_a = w_a_neg ? -oper1_i : oper1_i;
    assign w_abs_b = w_b_neg ? -oper2_i : oper2_i;

    // Restoring step; the quotient register doubles as the dividend shifter.
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge     = !w_diff[DATA_W+1];
    assign w_rem_nx = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};

    assign w_q_fin = r_dz ? {DATA_W{1'b1}} : (r_neg_q ? -w_quo_nx : w_quo_nx);
    assign w_r_fin = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_sel_rem <= 1'b0;
        end else if (ex_flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_quo     <= w_abs_a;
                        r_rem     <= '0;
                        r_dvs     <= w_abs_b;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_dz      <= (oper2_i == '0);
                        r_sel_rem <= div_rem_i;
                        r_cnt     <= CW'(DATA_W);
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_result <= r_sel_rem ? w_r_fin : w_q_fin;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (mem_allowin_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_ready_go = ((r_state == S_IDLE) & !w_issue) | (r_state == S_DONE);
    assign w_div_res  = r_result;
`else
    logic w_unused;

    assign w_unused   = ^{clk, rst, div_signed_i, div_rem_i, oper1_i, oper2_i};
    assign w_ready_go = 1'b1;
    assign w_div_res  = '0;
`endif

    assign ex_allowin_o      = !ex_valid_i | (w_ready_go & mem_allowin_i);
    assign ex_to_mem_valid_o = ex_valid_i & w_ready_go & !ex_flush_i;
    assign result_o          = div_en_i ? w_div_res : alu_rl_i;
    assign regs_we_o         = regs_we_i & ex_to_mem_valid_o;
    assign mem_addr_o        = mem_req_i ? alu_rl_i : '0;

    logic [2:0]        w_off;
    logic [7:0]        w_base;
    logic              w_mis;
    logic [NB-1:0]     w_mask;
    logic [DATA_W-1:0] w_wdata;

    assign w_off = 3'(alu_rl_i[OW-1:0]);

    always_comb begin
        w_base  = 8'h00;
        w_mis   = 1'b0;
        w_wdata = '0;
        case (mem_size_i)
            2'b00: begin
                w_base  = 8'h01;
                w_wdata = {NB{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_base  = 8'h03;
                w_mis   = w_off[0];
                w_wdata = {(NB/2){mem_wdata_i[15:0]}};
            end
            2'b10: begin
                w_base  = 8'h0F;
                w_mis   = |w_off[1:0];
                w_wdata = {(NB/4){mem_wdata_i[31:0]}};
            end
            default: begin
                // A dword never fits a 32-bit lane set.
                w_base  = 8'hFF;
                w_mis   = (DATA_W == 32) | (|w_off);
                w_wdata = mem_wdata_i;
            end
        endcase
    end

    assign w_mask      = NB'(w_base) << w_off;
    assign mem_ale_o   = mem_req_i & w_mis;
    assign mem_wdata_o = w_wdata;
    assign mem_we_o    = (ex_valid_i & mem_we_i & !mem_ale_o & !ex_flush_i)
                         ? w_mask : '0;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: divider scoreboard, handshake, store strobes.
module tb_ex_stage_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ex_valid, mem_allowin, ex_flush;
    logic        allowin, valid_o;
    logic        div_en, div_signed, div_rem;
    logic [31:0] oper1, oper2, alu, wdata;
    logic        regs_we, mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] result, maddr, wdata_o;
    logic        regs_we_o, ale;
    logic [3:0]  we_o;

    logic        v64, req64, we64, allow64, valid64, rwe64, ale64;
    logic [1:0]  size64;
    logic [63:0] alu64, wd64, res64, addr64, wdo64;
    logic [7:0]  we64_o;

    ex_stage_mc #(.DATA_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .mem_allowin_i(mem_allowin),
        .ex_flush_i(ex_flush), .ex_allowin_o(allowin),
        .ex_to_mem_valid_o(valid_o),
        .div_en_i(div_en), .div_signed_i(div_signed), .div_rem_i(div_rem),
        .oper1_i(oper1), .oper2_i(oper2), .alu_rl_i(alu),
        .regs_we_i(regs_we), .mem_req_i(mem_req), .mem_we_i(mem_we),
        .mem_size_i(mem_size), .mem_wdata_i(wdata),
        .result_o(result), .regs_we_o(regs_we_o), .mem_addr_o(maddr),
        .mem_we_o(we_o), .mem_wdata_o(wdata_o), .mem_ale_o(ale)
    );

    ex_stage_mc #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .ex_valid_i(v64), .mem_allowin_i(1'b1),
        .ex_flush_i(1'b0), .ex_allowin_o(allow64),
        .ex_to_mem_valid_o(valid64),
        .div_en_i(1'b0), .div_signed_i(1'b0), .div_rem_i(1'b0),
        .oper1_i(64'd0), .oper2_i(64'd0), .alu_rl_i(alu64),
        .regs_we_i(1'b0), .mem_req_i(req64), .mem_we_i(we64),
        .mem_size_i(size64), .mem_wdata_i(wd64),
        .result_o(res64), .regs_we_o(rwe64), .mem_addr_o(addr64),
        .mem_we_o(we64_o), .mem_wdata_o(wdo64), .mem_ale_o(ale64)
    );

`ifdef EX_DIV_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 0;
`endif

    int npass = 0;
    int ntot  = 0;
    logic [31:0] sbq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, b,
                                          input logic sg, rm);
`ifdef EX_DIV_EN
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return rm ? 32'd0 : 32'h8000_0000;
        if (sg) return rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return rm ? a % b : a / b;
`else
        return (a ^ b ^ {31'd0, sg ^ rm}) & 32'd0;
`endif
    endfunction

    task automatic drive_div(input logic [31:0] a, b, input logic sg, rm);
        @(posedge clk); #1;
        ex_valid = 1'b1; div_en = 1'b1; regs_we = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0;
        oper1 = a; oper2 = b; div_signed = sg; div_rem = rm;
    endtask

    task automatic wait_valid(output int cyc, output bit ok);
        cyc = 0;
        @(negedge clk);
        while (!valid_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        ok = valid_o;
        if (!ok) begin
            ntot++;
            $error("FAIL timeout observed=no_valid expected=valid");
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, b,
                           input logic sg, rm);
        int  cyc;
        bit  ok;
        drive_div(a, b, sg, rm);
        sbq.push_back(model(a, b, sg, rm));
        wait_valid(cyc, ok);
        if (ok) begin
            chk({tag, "_res"}, {32'd0, result}, {32'd0, sbq.pop_front()});
            chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
            chk({tag, "_rwe"}, {63'd0, regs_we_o}, 64'd1);
        end else begin
            void'(sbq.pop_front());
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; div_en = 1'b0;
    endtask

    logic [31:0] st_addr [7] = '{32'h103, 32'h103, 32'h102, 32'h104,
                                 32'h106, 32'h100, 32'h101};
    logic [1:0]  st_size [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [3:0]  st_we   [7] = '{4'b1000, 4'b0000, 4'b1100, 4'b1111,
                                 4'b0000, 4'b0000, 4'b0010};
    logic        st_ale  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] st_wd   [7] = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'h56AB_56AB,
                                 32'h1234_56AB, 32'h1234_56AB, 32'h1234_56AB,
                                 32'hABAB_ABAB};

    logic [63:0] d_addr [4] = '{64'h8, 64'hC, 64'h6, 64'h5};
    logic [1:0]  d_size [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
    logic [7:0]  d_we   [4] = '{8'hFF, 8'hF0, 8'h00, 8'h20};
    logic        d_ale  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int  cyc;
        bit  ok;
        logic [31:0] exp;
        rst = 1'b1;
        ex_valid = 0; mem_allowin = 1; ex_flush = 0;
        div_en = 0; div_signed = 0; div_rem = 0;
        oper1 = 0; oper2 = 0; alu = 0; wdata = 0;
        regs_we = 0; mem_req = 0; mem_we = 0; mem_size = 0;
        v64 = 0; req64 = 0; we64 = 0; size64 = 0; alu64 = 0; wd64 = 0;
        #12;
        chk("rst_allowin", {63'd0, allowin}, 64'd1);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_rwe", {63'd0, regs_we_o}, 64'd0);
        chk("rst_we", {60'd0, we_o}, 64'd0);
        chk("rst_ale", {63'd0, ale}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        @(posedge clk); #1;
        ex_valid = 1; alu = 32'h55; regs_we = 1;
        @(negedge clk);
        chk("alu_valid", {63'd0, valid_o}, 64'd1);
        chk("alu_res", {32'd0, result}, 64'h55);
        chk("alu_rwe", {63'd0, regs_we_o}, 64'd1);
        chk("alu_addr", {32'd0, maddr}, 64'd0);
        chk("alu_allowin", {63'd0, allowin}, 64'd1);

        run_div("u_q", 32'd100, 32'd7, 1'b0, 1'b0);
        run_div("u_r", 32'd100, 32'd7, 1'b0, 1'b1);
        run_div("s_q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_div("s_r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        run_div("min_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_div("min_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_div("dz_q", 32'h1234, 32'd0, 1'b0, 1'b0);
        run_div("dz_r", 32'h1234, 32'd0, 1'b0, 1'b1);
        run_div("dzs_q", 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0);

        drive_div(32'd50, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        chk("issue_allowin", {63'd0, allowin}, (LAT != 0) ? 64'd0 : 64'd1);
        repeat (10) @(posedge clk);
        #1 ex_flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", {63'd0, valid_o}, 64'd0);
        @(posedge clk); #1;
        ex_flush = 1'b0; div_en = 1'b0; alu = 32'h77;
        @(negedge clk);
        chk("flush_idle", {63'd0, valid_o}, 64'd1);
        chk("flush_res", {32'd0, result}, 64'h77);
        run_div("after_flush", 32'd100, 32'd7, 1'b0, 1'b0);

        mem_allowin = 1'b0;
        drive_div(32'd200, 32'd9, 1'b0, 1'b0);
        exp = model(32'd200, 32'd9, 1'b0, 1'b0);
        wait_valid(cyc, ok);
        if (ok) begin
            chk("bp_lat", 64'(cyc), 64'(LAT));
            for (int k = 0; k < 3; k++) begin
                chk("bp_hold_valid", {63'd0, valid_o}, 64'd1);
                chk("bp_hold_allow", {63'd0, allowin}, 64'd0);
                chk("bp_hold_res", {32'd0, result}, {32'd0, exp});
                @(negedge clk);
            end
            @(posedge clk); #1;
            mem_allowin = 1'b1;
            @(negedge clk);
            chk("bp_rel_allow", {63'd0, allowin}, 64'd1);
            chk("bp_rel_res", {32'd0, result}, {32'd0, exp});
        end
        mem_allowin = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; div_en = 1'b0;

        drive_div(32'd1000, 32'd7, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; div_en = 1'b0; alu = 32'h99;
        #1 chk("rst_mid_valid", {63'd0, valid_o}, 64'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_res", {32'd0, result}, 64'h99);
        run_div("after_rst", 32'd1000, 32'd7, 1'b0, 1'b1);

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            ex_valid = 1; div_en = 0; mem_req = 1; mem_we = 1;
            alu = st_addr[i]; mem_size = st_size[i]; wdata = 32'h1234_56AB;
            v64 = 1; req64 = 1; we64 = 1;
            if (i < 4) begin
                alu64 = d_addr[i]; size64 = d_size[i];
            end
            @(negedge clk);
            chk("st_we", {60'd0, we_o}, {60'd0, st_we[i]});
            chk("st_ale", {63'd0, ale}, {63'd0, st_ale[i]});
            chk("st_wdata", {32'd0, wdata_o}, {32'd0, st_wd[i]});
            chk("st_addr", {32'd0, maddr}, {32'd0, st_addr[i]});
            if (i < 4) begin
                chk("st64_we", {56'd0, we64_o}, {56'd0, d_we[i]});
                chk("st64_ale", {63'd0, ale64}, {63'd0, d_ale[i]});
            end
        end

        @(posedge clk); #1;
        alu = 32'h103; mem_size = 2'd0; ex_flush = 1'b1;
        @(negedge clk);
        chk("st_flush_we", {60'd0, we_o}, 64'd0);
        chk("st_flush_valid", {63'd0, valid_o}, 64'd0);
        @(posedge clk); #1;
        ex_flush = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("ld_we", {60'd0, we_o}, 64'd0);
        chk("ld_addr", {32'd0, maddr}, 64'h103);

        @(posedge clk); #1;
        ex_valid = 0; mem_req = 0; v64 = 0; req64 = 0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Multi-cycle execute stage for the scalar in-order pipeline. It sits between the ID/EX and EX/MEM latches. It adds a parametrised data width, generalised store byte-strobe and alignment checking, and an iterative signed/unsigned divider. The divider holds the stage with a real `ready_go`, which replaces the always-ready execute stage.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width; legal values are 32 and 64. `NB = DATA_W/8` byte lanes.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid_i`  in  1  EX holds a valid instruction (from the ID/EX latch).
- `mem_allowin_i`  in  1  MEM can accept an instruction this cycle.
- `ex_flush_i`  in  1  kill the instruction in EX, including any division in progress.
- `ex_allowin_o`  out  1  ID/EX latch may load.
- `ex_to_mem_valid_o`  out  1  EX result is valid toward EX/MEM.
- `div_en_i`  in  1  instruction is a divide.
- `div_signed_i`  in  1  1 = signed, 0 = unsigned.
- `div_rem_i`  in  1  1 = return remainder, 0 = return quotient.
- `oper1_i`, `oper2_i`  in  DATA_W  dividend and divisor.
- `alu_rl_i`  in  DATA_W  combinational ALU result (also the memory address).
- `regs_we_i`  in  1  write the register file.
- `mem_req_i`, `mem_we_i`  in  1 each  memory access and store.
- `mem_size_i`  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when `DATA_W`=64).
- `mem_wdata_i`  in  DATA_W  store data, right-aligned.
- `result_o`  out  DATA_W  divider result if `div_en_i`, else `alu_rl_i`.
- `regs_we_o`  out  1  `regs_we_i & ex_to_mem_valid_o`.
- `mem_addr_o`  out  DATA_W  `alu_rl_i` when `mem_req_i`, else 0.
- `mem_we_o`  out  NB  byte write strobes.
- `mem_wdata_o`  out  DATA_W  store data replicated across all lanes.
- `mem_ale_o`  out  1  misaligned access detected.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset value is IDLE; counter, quotient, remainder and result registers all reset to 0.
- IDLE:
  - If `ex_valid_i & div_en_i & !ex_flush_i`: latch |dividend| and |divisor| (absolute values taken only when signed), record the result signs, set counter = `DATA_W`, go to BUSY.
  - Otherwise `ready_go` = 1.
- BUSY:
  - One restoring shift-subtract step per cycle; counter decrements.
  - When counter reaches 1, go to DONE.
  - `ready_go` = 0.
- DONE:
  - Result is registered and sign-corrected.
  - Quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
  - `ready_go` = 1; go to IDLE when `mem_allowin_i`.
- `ex_flush_i` in any state forces IDLE at the next edge and drives `ex_to_mem_valid_o` = 0 that cycle.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed MIN / -1: quotient = MIN, remainder = 0.
- Handshake:
  - `ex_allowin_o = !ex_valid_i | (ready_go & mem_allowin_i)`.
  - `ex_to_mem_valid_o = ex_valid_i & ready_go & !ex_flush_i`.
- Store strobes:
  - `off = alu_rl_i[log2(NB)-1:0]`.
  - Base mask: byte 1, half 2'b11, word 4'hF, dword 8'hFF; `mem_we_o` = base mask << `off`.
  - `mem_ale_o = mem_req_i & (off mod size ≠ 0)`; it also asserts for dword when `DATA_W`=32.
  - `mem_we_o` = 0 unless `ex_valid_i & mem_we_i & !mem_ale_o & !ex_flush_i`.
- Reset value of every output:
  - `ex_allowin_o` = 1.
  - `ex_to_mem_valid_o`, `regs_we_o`, `mem_we_o`, `mem_ale_o` = 0 when inputs are idle.
  - Combinational outputs follow their inputs.

## Timing
- Non-divide instruction: 0 extra cycles; it passes in its arrival cycle when `mem_allowin_i` = 1.
- Divide issued in cycle 0:
  - BUSY in cycles 1..`DATA_W`.
  - DONE in cycle `DATA_W`+1, where `ex_to_mem_valid_o` = 1.
  - Total latency is `DATA_W`+1 cycles to ready.
- MEM backpressure in DONE: the result is held and the state stays DONE.
- The ID/EX contents must stay stable while `ex_allowin_o` = 0, which the upstream latch guarantees.
- Reset asserted mid-division: the FSM goes to IDLE asynchronously and the result is discarded.
- Flush and issue in the same IDLE cycle: the flush wins and no division starts.

## Configuration
- `EX_DIV_EN` defined: divider FSM compiled in, behaving as described above.
- `EX_DIV_EN` undefined:
  - No divider registers are built; `ready_go` is constant 1.
  - Divide instructions complete in one cycle with `result_o` = 0.
  - The FSM outputs are tied off.

## Test plan
- `DATA_W`=32, unsigned 100 / 7, MEM always ready → `result_o` = 14 in cycle 33 (quotient); with `div_rem_i`=1 → 2.
- Signed -7 / 2 → quotient -3, remainder -1. Signed 0x80000000 / -1 → quotient 0x80000000, remainder 0.
- Divide by zero, dividend 0x1234 → quotient 0xFFFFFFFF, remainder 0x1234.
- Store at address 0x…3: byte → `mem_we_o` = 4'b1000; half → `mem_ale_o` = 1, `mem_we_o` = 0. `DATA_W`=64, dword at 0x…8 → 8'hFF.
- Flush at cycle 10 of a division → IDLE at cycle 11, no `ex_to_mem_valid_o`; the next divide starts cleanly.
- Division in DONE with `mem_allowin_i` = 0 for 3 cycles → result held and `ex_allowin_o` = 0, then the stage fires on release.
